// File: rtl/module_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : module_keypad_scanner
// Purpose  : Scans a 4x4 active-low matrix keypad one column at a time,
//            debounces presses and releases, emits one code pulse per press
//            and accumulates decimal digits into a 4-digit packed-BCD value.
// Ports    : clk_i       - system clock
//            rst_i       - asynchronous active-low reset
//            row_i[3:0]  - keypad rows, active low, asynchronous to clk_i
//            col_o[3:0]  - column drive, active low, exactly one bit low
//            key_o[3:0]  - code of the last accepted key
//            key_valid_o - one-cycle pulse when key_o updates
//            enter_o     - one-cycle pulse when '#' is accepted
//            bcd_o[15:0] - entered number, [3:0] = least significant digit
// Revision : 1.0 - initial release
// ============================================================================
module module_keypad_scanner #(
    parameter int SCAN_PERIOD     = 27000,   // cycles per column, >= 4
    parameter int DEBOUNCE_CYCLES = 540000   // stable cycles to accept, >= 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic        enter_o,
    output logic [15:0] bcd_o
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_PERIOD) ? DEBOUNCE_CYCLES : SCAN_PERIOD;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] C_SCAN_RELOAD = CW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] C_DEB_RELOAD  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q;
    logic [3:0]    rs_q;                 // synchronized rows
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          enter_q, enter_d;
    logic [15:0]   bcd_q, bcd_d;

    logic          w_any_low;
    logic [1:0]    w_low_row;
    logic          w_row_high;
    logic [3:0]    w_code;

    // Key map: {row, col} -> code
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; idle rows read high
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 4'b1111;
            rs_q    <= 4'b1111;
        end else begin
            sync1_q <= row_i;
            rs_q    <= sync1_q;
        end
    end

    // Lowest-index low row wins when several keys share a column
    always_comb begin
        w_any_low = ~(&rs_q);
        w_low_row = 2'd3;
        if (!rs_q[0])      w_low_row = 2'd0;
        else if (!rs_q[1]) w_low_row = 2'd1;
        else if (!rs_q[2]) w_low_row = 2'd2;
    end

    assign w_row_high = rs_q[row_idx_q];
    assign w_code     = key_code(row_idx_q, col_idx_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= C_SCAN_RELOAD;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            enter_q     <= 1'b0;
            bcd_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            enter_q     <= enter_d;
            bcd_q       <= bcd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        enter_d     = 1'b0;
        bcd_d       = bcd_q;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == '0) begin
                    // Rows are sampled only at the end of the dwell so the
                    // synchronizer has settled on the current column.
                    if (w_any_low) begin
                        row_idx_d = w_low_row;
                        cnt_d     = C_DEB_RELOAD;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = C_SCAN_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (w_row_high) begin
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = C_SCAN_RELOAD;
                    state_d   = ST_SCAN;
                end else if (cnt_q == '0) begin
                    key_d       = w_code;
                    key_valid_d = 1'b1;
                    if (w_code <= 4'd9)
                        bcd_d = {bcd_q[11:0], w_code};
                    else if (w_code == 4'd14)
                        bcd_d = 16'h0000;
                    else if (w_code == 4'd15)
                        enter_d = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_HELD: begin
                if (w_row_high) begin
                    cnt_d   = C_DEB_RELOAD;
                    state_d = ST_RELEASE;
                end
            end

            default: begin // ST_RELEASE
                if (!w_row_high) begin
                    state_d = ST_HELD;
                end else if (cnt_q == '0) begin
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = C_SCAN_RELOAD;
                    state_d   = ST_SCAN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign col_o       = ~(4'b0001 << col_idx_q);
    assign key_o       = key_q;
    assign key_valid_o = key_valid_q;
    assign enter_o     = enter_q;
    assign bcd_o       = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_module_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_keypad_scanner
// Purpose  : Self-checking bench for module_keypad_scanner with a physical
//            keypad model (pressed keys short rows to driven columns) and a
//            scoreboard fed from a decimal reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_module_keypad_scanner;

    localparam int SP = 4;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [3:0]  key_o;
    logic        key_valid_o;
    logic        enter_o;
    logic [15:0] bcd_o;

    logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, col c held

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic        enter;
        logic [15:0] bcd;
        logic [1:0]  col;
    } exp_t;

    exp_t sb_q[$];
    int   model_val = 0;              // entered number as a plain integer
    int   keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    module_keypad_scanner #(
        .SCAN_PERIOD     (SP),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .enter_o     (enter_o),
        .bcd_o       (bcd_o)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key links it to a low column
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_expected(input int code, input int col);
        exp_t e;
        if (code <= 9)       model_val = (model_val * 10 + code) % 10000;
        else if (code == 14) model_val = 0;
        e.code  = 4'(code);
        e.enter = (code == 15);
        e.bcd   = to_bcd(model_val);
        e.col   = 2'(col);
        sb_q.push_back(e);
    endtask

    function automatic int key_index(input int code);
        int idx = 0;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) idx = i;
        return idx;
    endfunction

    task automatic key_down(input int code, input int bounce, input bit expect_pulse);
        int idx = key_index(code);
        for (int i = 0; i < bounce; i++) begin
            pressed[idx] = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        pressed[idx] = 1'b1;
        if (expect_pulse) push_expected(code, idx % 4);
    endtask

    task automatic key_up(input int code);
        pressed[key_index(code)] = 1'b0;
    endtask

    // Every expected pulse must have arrived by now; leftovers are misses
    task automatic check_drained(input string name);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic press(input int code, input int hold, input int gap, input int bounce);
        key_down(code, bounce, 1'b1);
        repeat (hold) @(negedge clk);
        key_up(code);
        repeat (gap) @(negedge clk);
        check_drained("missing_pulse");
    endtask

    // Monitor: pops the scoreboard on every pulse and watches column order
    logic [3:0] prev_col;
    logic [3:0] exp_next_col;
    bit         col_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            col_pending = 1'b0;
        end else begin
            check("col_one_low", $countones(~col_o), 1);
            if (enter_o) check("enter_with_valid", int'(key_valid_o), 1);
            if (col_pending && col_o != prev_col) begin
                check("col_after_release", col_o, exp_next_col);
                col_pending = 1'b0;
            end
            if (key_valid_o) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: key_o=%0d, expected no pulse", key_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pulse_key",   key_o,          e.code);
                    check("pulse_enter", int'(enter_o),  int'(e.enter));
                    check("pulse_bcd",   bcd_o,          e.bcd);
                    exp_next_col = ~(4'b0001 << (e.col + 2'd1));
                    col_pending  = 1'b1;
                end
            end
        end
        prev_col = col_o;
    end

    initial begin
        logic [3:0] exp_col;

        // 1. Reset values and free-running column scan
        repeat (3) @(negedge clk);
        check("rst_col",   col_o, 4'hE);
        check("rst_key",   key_o, 0);
        check("rst_valid", int'(key_valid_o), 0);
        check("rst_enter", int'(enter_o), 0);
        check("rst_bcd",   bcd_o, 0);
        rst_i = 1'b1;
        for (int p = 1; p <= 16; p++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((p / SP) % 4));
            check("scan_col", col_o, exp_col);
        end

        // 2. Single press of '5'
        press(5, 60, 40, 0);
        check("key_5", key_o, 5);
        check("bcd_5", bcd_o, 16'h0005);

        // 3. Bouncing '8'
        press(8, 60, 40, 15);
        check("key_8", key_o, 8);

        // 4. Digit entry then clear
        for (int d = 1; d <= 5; d++) press(d, 50, 30, 0);
        check("bcd_digits", bcd_o, 16'h2345);
        press(14, 50, 30, 0);
        check("bcd_clear", bcd_o, 16'h0000);
        check("key_star",  key_o, 14);

        // 5. Enter and letter keys
        press(4, 50, 30, 0);
        press(2, 50, 30, 0);
        check("bcd_42", bcd_o, 16'h0042);
        press(15, 50, 30, 0);
        check("key_hash",      key_o, 15);
        check("bcd_hash_keep", bcd_o, 16'h0042);
        press(10, 50, 30, 0);
        check("key_A",      key_o, 10);
        check("bcd_A_keep", bcd_o, 16'h0042);

        // 6a. Reset while '7' is held, then re-accept after release of reset
        key_down(7, 0, 1'b1);
        repeat (50) @(negedge clk);
        check("key_7_held", key_o, 7);
        rst_i = 1'b0;
        #1;
        check("midrst_col",   col_o, 4'hE);
        check("midrst_key",   key_o, 0);
        check("midrst_valid", int'(key_valid_o), 0);
        check("midrst_enter", int'(enter_o), 0);
        check("midrst_bcd",   bcd_o, 0);
        model_val = 0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        push_expected(7, key_index(7) % 4);
        rst_i = 1'b1;
        repeat (60) @(negedge clk);
        key_up(7);
        repeat (40) @(negedge clk);
        check_drained("missing_pulse_7");
        check("bcd_7", bcd_o, 16'h0007);

        // 6b. '2' pressed while '1' is held produces nothing
        key_down(1, 0, 1'b1);
        repeat (50) @(negedge clk);
        key_down(2, 0, 1'b0);
        repeat (40) @(negedge clk);
        key_up(1);
        key_up(2);
        repeat (40) @(negedge clk);
        check_drained("missing_pulse_1");
        check("key_1_only", key_o, 1);

        // Randomized presses, some with bounce
        for (int n = 0; n < 24; n++) begin
            int code;
            int bounce;
            code   = keymap[$urandom_range(0, 15)];
            bounce = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15)) : 0;
            press(code, int'($urandom_range(45, 80)), int'($urandom_range(25, 40)), bounce);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
